// File: rtl/vga_timing_receiver.sv
// vga_timing_receiver
//   Sink-side timing recovery for the board's VGA sync outputs. Synchronizes
//   VGA_HS/VGA_VS, recovers pixel/line coordinates aligned to line/frame
//   start, measures line period, HS width, lines per frame and VS width, and
//   declares the timing locked after LOCK_FRAMES consecutive matching frames.
//
// Ports
//   CLOCK_50    : single clock for all logic
//   RESET       : synchronous, active-high reset
//   VGA_HS      : horizontal sync, active low, line starts on falling edge
//   VGA_VS      : vertical sync, active low, frame starts on falling edge
//   rx_x        : clocks since last HS falling edge (saturating)
//   rx_y        : lines since last VS falling edge (saturating)
//   h_period    : last measured line length in clocks
//   h_sync      : last measured HS low width in clocks
//   v_lines     : last measured frame length in lines
//   v_sync      : last measured VS low width in lines
//   frame_start : one-cycle pulse on each detected VS falling edge
//   locked      : timing stable
module vga_timing_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FRAMES = 2,
    parameter int HW          = 12,
    parameter int VW          = 11
) (
    input  logic          CLOCK_50,
    input  logic          RESET,
    input  logic          VGA_HS,
    input  logic          VGA_VS,
    output logic [HW-1:0] rx_x,
    output logic [VW-1:0] rx_y,
    output logic [HW-1:0] h_period,
    output logic [HW-1:0] h_sync,
    output logic [VW-1:0] v_lines,
    output logic [VW-1:0] v_sync,
    output logic          frame_start,
    output logic          locked
);

    localparam int            CW     = $clog2(LOCK_FRAMES + 1);
    localparam logic [HW-1:0] X_MAX  = '1;
    localparam logic [VW-1:0] Y_MAX  = '1;
    localparam logic [CW-1:0] LOCK_N = CW'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, CHECK, LOCKED} state_t;

    logic [SYNC_STAGES-1:0] hs_sr, vs_sr;
    logic                   hs_s, vs_s;
    logic                   hs_d, vs_d;
    logic                   hs_fall, hs_rise, vs_fall, vs_rise;
    logic [VW-1:0]          vs_cnt;
    logic [HW-1:0]          line_per;
    logic [VW-1:0]          frame_len;
    logic                   per_bad;
    logic                   sync_lost;

    state_t                 state;
    logic                   have_ref;
    logic [HW-1:0]          ref_h;
    logic [VW-1:0]          ref_v;
    logic [CW-1:0]          match_cnt;

    assign hs_s = hs_sr[SYNC_STAGES-1];
    assign vs_s = vs_sr[SYNC_STAGES-1];

    // Length of the line / frame that ends on this edge.
    assign line_per  = rx_x + 1'b1;
    assign frame_len = rx_y + 1'b1;
    assign per_bad   = hs_fall && (line_per != ref_h);
    // A line start in the same cycle rescues a saturated counter.
    assign sync_lost = (rx_x == X_MAX) && !hs_fall;

    assign frame_start = vs_fall;

    // Synchronizers and registered edge detect; idle level is high so a
    // reset never fabricates an edge.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            hs_sr   <= '1;
            vs_sr   <= '1;
            hs_d    <= 1'b1;
            vs_d    <= 1'b1;
            hs_fall <= 1'b0;
            hs_rise <= 1'b0;
            vs_fall <= 1'b0;
            vs_rise <= 1'b0;
        end else begin
            hs_sr   <= {hs_sr[SYNC_STAGES-2:0], VGA_HS};
            vs_sr   <= {vs_sr[SYNC_STAGES-2:0], VGA_VS};
            hs_d    <= hs_s;
            vs_d    <= vs_s;
            hs_fall <= hs_d & ~hs_s;
            hs_rise <= ~hs_d & hs_s;
            vs_fall <= vs_d & ~vs_s;
            vs_rise <= ~vs_d & vs_s;
        end
    end

    // Coordinates and measurements. vs_d is the VS level aligned with
    // vs_fall/vs_rise, so it marks the lines inside the VS pulse.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            rx_x     <= '0;
            rx_y     <= '0;
            h_period <= '0;
            h_sync   <= '0;
            v_lines  <= '0;
            v_sync   <= '0;
            vs_cnt   <= '0;
        end else begin
            if (hs_fall)
                rx_x <= '0;
            else if (rx_x != X_MAX)
                rx_x <= rx_x + 1'b1;

            if (hs_fall) h_period <= line_per;
            if (hs_rise) h_sync   <= line_per;

            if (vs_fall)
                rx_y <= '0;
            else if (hs_fall && rx_y != Y_MAX)
                rx_y <= rx_y + 1'b1;

            if (vs_fall) v_lines <= frame_len;

            // The line that starts with the VS fall is the first VS line;
            // the line that starts with the VS rise is not counted.
            if (vs_fall)
                vs_cnt <= hs_fall ? VW'(1) : '0;
            else if (hs_fall && !vs_d && vs_cnt != Y_MAX)
                vs_cnt <= vs_cnt + 1'b1;

            if (vs_rise) v_sync <= vs_cnt;
        end
    end

    // Lock FSM. Comparisons use the length that completes on this edge,
    // i.e. the value h_period/v_lines take on at the same clock.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            have_ref  <= 1'b0;
            ref_h     <= '0;
            ref_v     <= '0;
            match_cnt <= '0;
        end else if (sync_lost) begin
            state  <= SEARCH;
            locked <= 1'b0;
        end else begin
            case (state)
                SEARCH: begin
                    if (vs_fall) begin
                        state    <= MEASURE;
                        have_ref <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (have_ref && per_bad) begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end else if (vs_fall) begin
                        if (!have_ref) ref_h <= line_per;
                        have_ref  <= 1'b1;
                        ref_v     <= frame_len;
                        match_cnt <= '0;
                        state     <= CHECK;
                    end else if (hs_fall && !have_ref) begin
                        ref_h    <= line_per;
                        have_ref <= 1'b1;
                    end
                end
                CHECK: begin
                    if (per_bad || (vs_fall && frame_len != ref_v)) begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end else if (vs_fall) begin
                        if ((match_cnt + 1'b1) == LOCK_N) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (per_bad || (vs_fall && frame_len != ref_v)) begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Scoreboard bench for vga_timing_receiver. The stimulus process acts as the
// VGA generator and pushes the hand-computed expected measurements for each
// frame as it starts it; the monitor pops an entry on every frame_start
// and compares one cycle later, when the measurements and lock have settled.
// Lock-phase timing uses a short frame (40 clk lines, HS 6, 12 lines, VS 2);
// the full-size line (1586 clk, HS 190) is measured in a final phase.
module tb_vga_timing_receiver;
    localparam int HW = 12;
    localparam int VW = 11;

    logic          CLOCK_50 = 1'b0;
    logic          RESET    = 1'b1;
    logic          VGA_HS   = 1'b1;
    logic          VGA_VS   = 1'b1;
    logic [HW-1:0] rx_x, h_period, h_sync;
    logic [VW-1:0] rx_y, v_lines, v_sync;
    logic          frame_start, locked;

    always #10 CLOCK_50 = ~CLOCK_50;

    vga_timing_receiver #(.SYNC_STAGES(2), .LOCK_FRAMES(2), .HW(HW), .VW(VW)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .rx_x(rx_x), .rx_y(rx_y), .h_period(h_period), .h_sync(h_sync),
        .v_lines(v_lines), .v_sync(v_sync), .frame_start(frame_start), .locked(locked)
    );

    // m: bit0 h_period, bit1 h_sync, bit2 v_lines, bit3 v_sync are checked
    typedef struct {
        logic [HW-1:0] hp;
        logic [HW-1:0] hs;
        logic [VW-1:0] vl;
        logic [VW-1:0] vs;
        logic          lk;
        logic [3:0]    m;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, passed = 0;
    int   cyc = 0, cx = 0, cy = 0;
    bit   gen_on = 1'b0;
    int   hs_w = 6, vs_w = 2;
    int   stretch_cyc = 0, fall_cyc = -100;
    int   n_fs = 0, coord_err = 0, coord_n = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic exp_t mk(input int hp, input int hs, input int vl, input int vs,
                                input bit lk, input logic [3:0] m);
        exp_t e;
        e.hp = HW'(hp); e.hs = HW'(hs); e.vl = VW'(vl); e.vs = VW'(vs);
        e.lk = lk; e.m = m;
        return e;
    endfunction

    // One generator frame; HS low for the first hs_w clocks of each line,
    // VS low for the first vs_w lines. Optional stretched line / reset point.
    task automatic gen_frame(input int line_len, input int nlines, input int stretch_line,
                             input int reset_line, input exp_t e);
        int len;
        sb.push_back(e);
        for (int y = 0; y < nlines; y++) begin
            len = (y == stretch_line) ? line_len + 1 : line_len;
            for (int x = 0; x < len; x++) begin
                @(negedge CLOCK_50);
                cx = x; cy = y; gen_on = 1'b1;
                VGA_HS = (x >= hs_w);
                VGA_VS = (y >= vs_w);
                if (stretch_line >= 0 && y == stretch_line + 1 && x == 0) stretch_cyc = cyc;
                if (y == reset_line && x == 20) begin
                    chk("locked_before_reset", locked, 1);
                    RESET = 1'b1;
                    @(posedge CLOCK_50); #1;
                    chk("midreset_coords", {rx_x, rx_y}, 0);
                    chk("midreset_hmeas", {h_period, h_sync}, 0);
                    chk("midreset_vmeas", {v_lines, v_sync}, 0);
                    chk("midreset_flags", {frame_start, locked}, 0);
                end else begin
                    RESET = 1'b0;
                end
            end
        end
    endtask

    // Monitor: cycle count, delayed-coordinate check while locked, lock-fall
    // timestamp, and scoreboard pop one cycle after each frame_start.
    initial begin
        int   hx[4], hy[4];
        bit   hv[4];
        bit   pend, lk_prev;
        exp_t e;
        pend = 1'b0; lk_prev = 1'b0;
        for (int i = 0; i < 4; i++) begin hx[i] = 0; hy[i] = 0; hv[i] = 1'b0; end
        forever begin
            @(posedge CLOCK_50); #1;
            cyc++;
            hx[cyc % 4] = cx; hy[cyc % 4] = cy; hv[cyc % 4] = gen_on;
            // rx_* after this edge reflect the input sampled 3 edges ago
            if (locked && hv[(cyc + 1) % 4]) begin
                coord_n++;
                if (int'(rx_x) != hx[(cyc + 1) % 4] || int'(rx_y) != hy[(cyc + 1) % 4])
                    coord_err++;
            end
            if (lk_prev && !locked) fall_cyc = cyc;
            lk_prev = locked;
            if (pend) begin
                n_fs++;
                chk($sformatf("f%0d_fs_pulse_width", n_fs), frame_start, 0);
                if (sb.size() == 0) begin
                    chk($sformatf("f%0d_sb_underflow", n_fs), 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("f%0d_locked", n_fs), locked, e.lk);
                    if (e.m[0]) chk($sformatf("f%0d_h_period", n_fs), h_period, e.hp);
                    if (e.m[1]) chk($sformatf("f%0d_h_sync", n_fs), h_sync, e.hs);
                    if (e.m[2]) chk($sformatf("f%0d_v_lines", n_fs), v_lines, e.vl);
                    if (e.m[3]) chk($sformatf("f%0d_v_sync", n_fs), v_sync, e.vs);
                    chk($sformatf("f%0d_coord_errs", n_fs), coord_err, 0);
                    coord_err = 0;
                end
            end
            pend = frame_start;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        exp_t n0, n1;
        bit   found;
        n0 = mk(40, 6, 12, 2, 1'b0, 4'hF);
        n1 = mk(40, 6, 12, 2, 1'b1, 4'hF);

        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("reset_coords", {rx_x, rx_y}, 0);
        chk("reset_meas", {h_period, h_sync, v_lines, v_sync}, 0);
        chk("reset_flags", {frame_start, locked}, 0);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        repeat (4) @(negedge CLOCK_50);

        // Nominal acquisition: lock after the 4th frame start
        gen_frame(40, 12, -1, -1, mk(0, 0, 1, 0, 1'b0, 4'b1110));
        gen_frame(40, 12, -1, -1, n0);
        gen_frame(40, 12, -1, -1, n0);
        gen_frame(40, 12, -1, -1, n1);
        gen_frame(40, 12, -1, -1, n1);
        // Line 5 stretched to 41 clocks while locked
        gen_frame(40, 12, 5, -1, n1);
        chk("stretch_unlock_latency", fall_cyc - stretch_cyc, 4);
        gen_frame(40, 12, -1, -1, n0);
        gen_frame(40, 12, -1, -1, n0);
        gen_frame(40, 12, -1, -1, n0);
        // Relocked; this frame drops a line
        gen_frame(40, 11, -1, -1, n1);
        gen_frame(40, 12, -1, -1, mk(40, 6, 11, 2, 1'b0, 4'hF));
        gen_frame(40, 12, -1, -1, n0);
        gen_frame(40, 12, -1, -1, n0);
        gen_frame(40, 12, -1, -1, n0);
        // Locked again; one-cycle reset at line 4
        gen_frame(40, 12, -1, 4, n1);
        // 7 line starts after the reset -> 8 lines; VS rise was before reset
        gen_frame(40, 12, -1, -1, mk(40, 6, 8, 0, 1'b0, 4'hF));
        gen_frame(40, 12, -1, -1, n0);
        gen_frame(40, 12, -1, -1, n0);
        gen_frame(40, 12, -1, -1, n1);

        // Sync loss: HS held high
        @(negedge CLOCK_50);
        gen_on = 1'b0; VGA_HS = 1'b1; VGA_VS = 1'b1;
        chk("locked_before_loss", locked, 1);
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge CLOCK_50);
            if (rx_x == 12'hFFF) found = 1'b1;
        end
        chk("rx_x_saturation_reached", found, 1);
        if (found) chk("locked_at_saturation", locked, 1);
        repeat (2) @(negedge CLOCK_50);
        chk("rx_x_saturation_hold", rx_x, 4095);
        chk("loss_unlock", locked, 0);

        // Full-size line timing, 4-line frames
        hs_w = 190;
        gen_frame(1586, 4, -1, -1, mk(0, 6, 12, 2, 1'b0, 4'b1110));
        gen_frame(1586, 4, -1, -1, mk(1586, 190, 4, 2, 1'b0, 4'hF));
        gen_frame(1586, 4, -1, -1, mk(1586, 190, 4, 2, 1'b0, 4'hF));
        @(negedge CLOCK_50);
        gen_on = 1'b0; VGA_HS = 1'b1; VGA_VS = 1'b1;
        repeat (10) @(negedge CLOCK_50);

        chk("frame_start_count", n_fs, 22);
        chk("scoreboard_drained", sb.size(), 0);
        chk("coord_samples_seen", coord_n > 0, 1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
